// File: rtl/inst_fetch_if.sv
// Fetch-stage bundle: instruction-memory request/response channel, redirect
// input and the instruction channel towards decode.
interface inst_fetch_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;

    modport master (
        output imem_req_valid, imem_req_addr, inst_valid, inst_out, inst_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
               redirect_valid, redirect_pc, inst_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, inst_valid, inst_out, inst_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
               redirect_valid, redirect_pc, inst_ready
    );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, issues in-order word fetches, keeps
// responses with their PC in an in-order slot buffer and hands them to decode.
// A redirect flushes the buffer and counts still-outstanding responses so they
// are dropped when they come back.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    inst_fetch_if.master bus
);
    localparam int unsigned   PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned   CW       = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);
    localparam logic [CW:0]   CAP      = (CW + 1)'(DEPTH);

    logic [31:0]      pc;
    logic [31:0]      slot_pc   [DEPTH];
    logic [31:0]      slot_data [DEPTH];
    logic [DEPTH-1:0] slot_filled;
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [PW-1:0]    fill_ptr;
    logic [CW-1:0]    used;
    logic [CW-1:0]    pend;       // allocated slots still waiting for data
    logic [CW-1:0]    drop_cnt;   // responses owed to flushed requests
    logic             started;

    logic [CW:0]      occupancy;
    logic [CW-1:0]    redirect_drop;
    logic             req_fire;
    logic             pop;
    logic             fill;
    logic             discard;

    function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] idx);
        return (idx == LAST_IDX) ? '0 : idx + 1'b1;
    endfunction

    assign bus.imem_req_valid = started & ~bus.redirect_valid & (occupancy < CAP);
    assign bus.imem_req_addr  = pc;
    assign bus.inst_valid     = slot_filled[head] & ~bus.redirect_valid;
    assign bus.inst_out       = slot_data[head];
    assign bus.inst_pc        = slot_pc[head];

    // Handshake qualification and the drop count a redirect would leave behind.
    always_comb begin
        occupancy = {1'b0, used} + {1'b0, drop_cnt};
        req_fire  = bus.imem_req_valid & bus.imem_req_ready;
        pop       = bus.inst_valid & bus.inst_ready;
        discard   = bus.imem_rsp_valid & (drop_cnt != '0);
        fill      = bus.imem_rsp_valid & (drop_cnt == '0) & (pend != '0) & ~bus.redirect_valid;
        redirect_drop = drop_cnt + pend;
        if (bus.imem_rsp_valid && (redirect_drop != '0)) begin
            redirect_drop = redirect_drop - 1'b1;
        end
    end

    // PC, slot buffer and pointer state; redirect overrides every other event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= {RESET_PC[31:2], 2'b00};
            head        <= '0;
            tail        <= '0;
            fill_ptr    <= '0;
            used        <= '0;
            pend        <= '0;
            drop_cnt    <= '0;
            started     <= 1'b0;
            slot_filled <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                slot_pc[i]   <= '0;
                slot_data[i] <= '0;
            end
        end else begin
            started <= 1'b1;
            if (bus.redirect_valid) begin
                pc          <= {bus.redirect_pc[31:2], 2'b00};
                head        <= '0;
                tail        <= '0;
                fill_ptr    <= '0;
                used        <= '0;
                pend        <= '0;
                drop_cnt    <= redirect_drop;
                slot_filled <= '0;
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    slot_pc[i]   <= '0;
                    slot_data[i] <= '0;
                end
            end else begin
                if (req_fire) begin
                    slot_pc[tail]     <= pc;
                    slot_data[tail]   <= '0;
                    slot_filled[tail] <= 1'b0;
                    tail              <= next_idx(tail);
                    pc                <= pc + 32'd4;
                end
                if (fill) begin
                    slot_data[fill_ptr]   <= bus.imem_rsp_data;
                    slot_filled[fill_ptr] <= 1'b1;
                    fill_ptr              <= next_idx(fill_ptr);
                end
                if (pop) begin
                    slot_pc[head]     <= '0;
                    slot_data[head]   <= '0;
                    slot_filled[head] <= 1'b0;
                    head              <= next_idx(head);
                end
                if (discard) begin
                    drop_cnt <= drop_cnt - 1'b1;
                end
                used <= used + CW'(req_fire) - CW'(pop);
                pend <= pend + CW'(req_fire) - CW'(fill);
            end
        end
    end
endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: a latency-randomised instruction memory plus a
// transaction-level model of which fetched words must reach decode, in order.
module tb_inst_fetch;
    localparam logic [31:0] RESET_PC = 32'h0000_0100;
    localparam int unsigned DEPTH    = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    inst_fetch_if bus();

    inst_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct { logic [31:0] pc; bit filled; } ent_t;
    typedef struct { logic [31:0] addr; int due; bit stale; } rsp_t;

    ent_t        q[$];    // fetched since last flush, not yet consumed
    rsp_t        pq[$];   // responses the memory still owes
    logic [31:0] m_pc;
    bit          m_started;
    int          cyc = 0;
    int          lat_min = 1;
    int          lat_max = 1;

    logic [31:0] fire_addr[$];
    int          fire_cyc[$];
    logic [31:0] deliv_pc[$];
    int          deliv_cyc[$];

    logic [97:0] obs_vec;
    logic [97:0] exp_vec;
    int          total = 0;
    int          bad   = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic clear_logs();
        fire_addr.delete(); fire_cyc.delete(); deliv_pc.delete(); deliv_cyc.delete();
    endtask

    // One clock: drive inputs, sample outputs against the model, advance the model.
    task automatic step(input bit rr, input bit ir, input bit redir, input logic [31:0] rpc);
        bit          rsp, e_rv, e_iv, fire, pop, found;
        int          stale_n;
        logic [31:0] e_pc, e_out;
        rsp_t        r;
        bus.imem_req_ready = rr;
        bus.inst_ready     = ir;
        bus.redirect_valid = redir;
        bus.redirect_pc    = rpc;
        rsp = (pq.size() > 0) && (pq[0].due <= cyc);
        bus.imem_rsp_valid = rsp;
        bus.imem_rsp_data  = rsp ? mem_word(pq[0].addr) : $urandom;
        #1;
        stale_n = 0;
        foreach (pq[i]) if (pq[i].stale) stale_n++;
        e_rv  = m_started && !redir && ((q.size() + stale_n) < int'(DEPTH));
        e_iv  = !redir && (q.size() > 0) && q[0].filled;
        e_pc  = e_iv ? q[0].pc : 32'h0;
        e_out = e_iv ? mem_word(q[0].pc) : 32'h0;
        exp_vec = {e_rv, e_rv ? m_pc : 32'h0, e_iv, e_pc, e_out};
        obs_vec = {bus.imem_req_valid, bus.imem_req_valid ? bus.imem_req_addr : 32'h0,
                   bus.inst_valid, bus.inst_valid ? bus.inst_pc : 32'h0,
                   bus.inst_valid ? bus.inst_out : 32'h0};
        fire = e_rv && rr;
        pop  = e_iv && ir;
        @(posedge clk);
        if (redir) begin
            if (rsp) void'(pq.pop_front());
            foreach (pq[i]) pq[i].stale = 1'b1;
            q.delete();
            m_pc = {rpc[31:2], 2'b00};
        end else begin
            if (rsp) begin
                r = pq.pop_front();
                if (!r.stale) begin
                    found = 1'b0;
                    for (int i = 0; i < q.size(); i++) begin
                        if (!q[i].filled) begin
                            q[i].filled = 1'b1;
                            found = 1'b1;
                            break;
                        end
                    end
                    if (!found) begin
                        bad++;
                        $display("FAIL protocol cyc=%0d response with no unfilled slot addr=%h", cyc, r.addr);
                    end
                end
            end
            if (pop) begin
                deliv_pc.push_back(q[0].pc);
                deliv_cyc.push_back(cyc);
                void'(q.pop_front());
            end
            if (fire) begin
                q.push_back('{m_pc, 1'b0});
                pq.push_back('{m_pc, cyc + int'($urandom_range(lat_max, lat_min)), 1'b0});
                fire_addr.push_back(m_pc);
                fire_cyc.push_back(cyc);
                m_pc = m_pc + 32'd4;
            end
        end
        m_started = 1'b1;
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.imem_req_ready = 1'b0; bus.inst_ready  = 1'b0;
        bus.redirect_valid = 1'b0; bus.redirect_pc = 32'h0;
        bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = 32'h0;
        q.delete(); pq.delete();
        m_pc = RESET_PC; m_started = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [97:0] z;
        rst_n = 1'b0;
        @(negedge clk); #1;
        z = {bus.imem_req_valid, bus.imem_req_addr ^ RESET_PC, bus.inst_valid, bus.inst_pc, bus.inst_out};
        total++;
        if (z !== 98'h0) begin bad++; $display("FAIL reset_hold got=%h want=0", z); end
        do_reset();
        #1;
        z = {bus.imem_req_valid, 32'h0, bus.inst_valid, bus.inst_pc, bus.inst_out};
        total++;
        if (z !== 98'h0) begin bad++; $display("FAIL reset_release got=%h want=0", z); end
        step(1, 1, 0, 32'h0);
        total++;
        if (obs_vec !== exp_vec) begin bad++; $display("FAIL first_cycle got=%h want=%h", obs_vec, exp_vec); end
    endtask

    task automatic test_stream();
        clear_logs();
        lat_min = 1; lat_max = 1;
        for (int i = 0; i < 14; i++) begin
            step(1, 1, 0, 32'h0);
            total++;
            if (obs_vec !== exp_vec) begin bad++; $display("FAIL stream cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec); end
        end
        total++;
        if (fire_addr.size() < 3 || fire_addr[0] !== 32'h100 || fire_addr[1] !== 32'h104 || fire_addr[2] !== 32'h108) begin
            bad++; $display("FAIL stream_addrs got=%0d fires first=%h want=100,104,108", fire_addr.size(), (fire_addr.size() > 0) ? fire_addr[0] : 32'hx);
        end
        total++;
        if (fire_cyc.size() == 0 || deliv_cyc.size() == 0 || (deliv_cyc[0] - fire_cyc[0]) != 2) begin
            bad++; $display("FAIL stream_latency got=%0d want=2", (deliv_cyc.size() > 0 && fire_cyc.size() > 0) ? deliv_cyc[0] - fire_cyc[0] : -1);
        end
        foreach (deliv_pc[k]) begin
            total++;
            if (deliv_pc[k] !== RESET_PC + 32'(4 * k)) begin
                bad++; $display("FAIL stream_order idx=%0d got=%h want=%h", k, deliv_pc[k], RESET_PC + 32'(4 * k));
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] last;
        last = (deliv_pc.size() > 0) ? deliv_pc[deliv_pc.size() - 1] : RESET_PC - 32'd4;
        clear_logs();
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0, 32'h0);
            total++;
            if (obs_vec !== exp_vec) begin bad++; $display("FAIL stall cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec); end
        end
        total++;
        if (obs_vec[97] !== 1'b0 || obs_vec[64] !== 1'b1) begin
            bad++; $display("FAIL stall_full got req_valid=%b inst_valid=%b want 0 1", obs_vec[97], obs_vec[64]);
        end
        for (int i = 0; i < 10; i++) begin
            step(1, 1, 0, 32'h0);
            total++;
            if (obs_vec !== exp_vec) begin bad++; $display("FAIL stall_release cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec); end
        end
        foreach (deliv_pc[k]) begin
            total++;
            if (deliv_pc[k] !== last + 32'(4 * (k + 1))) begin
                bad++; $display("FAIL stall_seq idx=%0d got=%h want=%h", k, deliv_pc[k], last + 32'(4 * (k + 1)));
            end
        end
    endtask

    task automatic test_req_backpressure();
        int held;
        do_reset();
        clear_logs();
        lat_min = 1; lat_max = 1;
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 0, 32'h0);
            total++;
            if (obs_vec !== exp_vec) begin bad++; $display("FAIL bp_pre cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec); end
        end
        held = 0;
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 0, 32'h0);
            total++;
            if (obs_vec !== exp_vec) begin bad++; $display("FAIL bp cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec); end
            if (obs_vec[97] === 1'b1) begin
                held++;
                total++;
                if (obs_vec[96:65] !== 32'h108) begin bad++; $display("FAIL bp_addr got=%h want=00000108", obs_vec[96:65]); end
            end
        end
        total++;
        if (held < 3) begin bad++; $display("FAIL bp_held got=%0d want>=3", held); end
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 0, 32'h0);
            total++;
            if (obs_vec !== exp_vec) begin bad++; $display("FAIL bp_post cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec); end
        end
        total++;
        if (fire_addr.size() < 3 || fire_addr[2] !== 32'h108) begin
            bad++; $display("FAIL bp_resume got=%h want=00000108", (fire_addr.size() > 2) ? fire_addr[2] : 32'hx);
        end
    endtask

    task automatic test_redirect();
        int  live;
        bit  ok;
        lat_min = 3; lat_max = 3;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            step(1, 1, 0, 32'h0);
            total++;
            if (obs_vec !== exp_vec) begin bad++; $display("FAIL redir_pre cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec); end
            live = 0;
            foreach (pq[k]) if (!pq[k].stale) live++;
            ok = (live >= 2);
        end
        total++;
        if (!ok) begin bad++; $display("FAIL redir_setup got=%0d in flight want=2", live); end
        clear_logs();
        step(1, 1, 1, 32'h2003);
        total++;
        if (obs_vec !== exp_vec) begin bad++; $display("FAIL redir_cycle got=%h want=%h", obs_vec, exp_vec); end
        for (int i = 0; i < 16; i++) begin
            step(1, 1, 0, 32'h0);
            total++;
            if (obs_vec !== exp_vec) begin bad++; $display("FAIL redir_post cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec); end
        end
        total++;
        if (fire_addr.size() == 0 || fire_addr[0] !== 32'h2000) begin
            bad++; $display("FAIL redir_addr got=%h want=00002000", (fire_addr.size() > 0) ? fire_addr[0] : 32'hx);
        end
        total++;
        if (deliv_pc.size() == 0 || deliv_pc[0] !== 32'h2000) begin
            bad++; $display("FAIL redir_first got=%h want=00002000", (deliv_pc.size() > 0) ? deliv_pc[0] : 32'hx);
        end
    endtask

    task automatic test_redirect_coincident();
        bit hit;
        lat_min = 1; lat_max = 1;
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            if (pq.size() > 0 && pq[0].due <= cyc && q.size() > 0 && q[0].filled) begin
                clear_logs();
                step(1, 1, 1, 32'h0000_3000);
                hit = 1'b1;
            end else begin
                step(1, 1, 0, 32'h0);
            end
            total++;
            if (obs_vec !== exp_vec) begin bad++; $display("FAIL coinc cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec); end
        end
        total++;
        if (!hit) begin bad++; $display("FAIL coinc_setup got=0 want=1"); end
        for (int i = 0; i < 12; i++) begin
            step(1, 1, 0, 32'h0);
            total++;
            if (obs_vec !== exp_vec) begin bad++; $display("FAIL coinc_post cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec); end
        end
        total++;
        if (deliv_pc.size() == 0 || deliv_pc[0] !== 32'h3000) begin
            bad++; $display("FAIL coinc_first got=%h want=00003000", (deliv_pc.size() > 0) ? deliv_pc[0] : 32'hx);
        end
    endtask

    task automatic test_async_reset();
        logic [97:0] z;
        lat_min = 1; lat_max = 1;
        for (int i = 0; i < 6; i++) begin
            step(1, 0, 0, 32'h0);
            total++;
            if (obs_vec !== exp_vec) begin bad++; $display("FAIL areset_fill cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec); end
        end
        #3;
        rst_n = 1'b0;
        #1;
        z = {bus.imem_req_valid, 32'h0, bus.inst_valid, bus.inst_pc, bus.inst_out};
        total++;
        if (z !== 98'h0) begin bad++; $display("FAIL areset_immediate got=%h want=0", z); end
        do_reset();
        clear_logs();
        for (int i = 0; i < 10; i++) begin
            step(1, 1, 0, 32'h0);
            total++;
            if (obs_vec !== exp_vec) begin bad++; $display("FAIL areset_post cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec); end
        end
        total++;
        if (fire_addr.size() == 0 || fire_addr[0] !== RESET_PC || deliv_pc.size() == 0 || deliv_pc[0] !== RESET_PC) begin
            bad++; $display("FAIL areset_restart got=%h want=%h", (deliv_pc.size() > 0) ? deliv_pc[0] : 32'hx, RESET_PC);
        end
    endtask

    task automatic test_random();
        bit          rr, ir, rd;
        logic [31:0] tgt;
        lat_min = 1; lat_max = 3;
        for (int i = 0; i < 600; i++) begin
            rr  = ($urandom_range(99, 0) < 75);
            ir  = ($urandom_range(99, 0) < 70);
            rd  = ($urandom_range(99, 0) < 5);
            tgt = ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFF4 + 32'($urandom_range(3, 0)) : $urandom;
            step(rr, ir, rd, tgt);
            total++;
            if (obs_vec !== exp_vec) begin bad++; $display("FAIL random cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec); end
        end
    endtask

    initial begin
        bus.imem_req_ready = 1'b0; bus.inst_ready  = 1'b0;
        bus.redirect_valid = 1'b0; bus.redirect_pc = 32'h0;
        bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = 32'h0;
        test_reset();
        test_stream();
        test_stall();
        test_req_backpressure();
        test_redirect();
        test_redirect_coincident();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
Instruction fetch stage, directly upstream of the instruction decoder. It holds the PC and issues in-order word fetches to instruction memory over a valid/ready request channel. Responses are buffered, each with its PC, in a small in-order slot buffer, and presented to the decode stage over a valid/ready handshake. Supports redirect (branch/jump target) with flush and discard of in-flight responses.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
DEPTH, 2, number of buffer slots; also the maximum number of in-flight requests (>=2)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  32  word address of request (= pc)
imem_rsp_valid  in  1  response valid; in order, no backpressure, earliest 1 cycle after accept
imem_rsp_data  in  32  fetched instruction word
redirect_valid  in  1  one-cycle redirect pulse
redirect_pc  in  32  redirect target
inst_valid  out  1  instruction available to decode
inst_ready  in  1  decode accepts instruction
inst_out  out  32  instruction word to decoder
inst_pc  out  32  PC of inst_out

Behaviour:
- State: pc[31:0]; slot array of DEPTH entries {pc, data, filled}; head/tail/fill pointers; used count (0..DEPTH); drop_cnt (0..DEPTH); started flag.
- Reset (async, rst_n low): pc=RESET_PC, used=0, drop_cnt=0, all filled=0, started=0. Outputs during and at reset: imem_req_valid=0, inst_valid=0, inst_out=0, inst_pc=0 when buffer empty. started sets on the first clk edge after deassertion. First request is in the cycle after that edge.
- Request: imem_req_valid = started & ~redirect_valid & (used + drop_cnt < DEPTH).
  - imem_req_addr = pc; pc[1:0] always 0.
  - On handshake: allocate tail slot {pc, filled=0}, tail++, used++, pc += 4 (wraps modulo 2^32).
  - Without handshake, pc and addr stay stable.
- Response (rsp_valid):
  - If drop_cnt>0: discard, drop_cnt--.
  - Otherwise: write data into the oldest unfilled slot, set filled. A response with no unfilled slot is a protocol error; the bench asserts on it.
- Output: inst_valid = slot[head].filled & ~redirect_valid; inst_out/inst_pc come from the head slot.
  - On inst_valid & inst_ready: clear head, head++, used--.
  - Same-cycle pop + allocate + fill is legal; used changes by the net amount.
- Latency: request accepted cycle N, response cycle N+1 → inst_valid cycle N+2. Steady-state throughput is 1 inst/cycle with DEPTH>=2 and inst_ready held high.
- Redirect (redirect_valid in cycle N) has priority over all other events:
  - No request is issued and no pop occurs in cycle N.
  - At edge N: pc = {redirect_pc[31:2], 2'b00}; all slots cleared, used=0, pointers reset.
  - drop_cnt = drop_cnt + (allocated-unfilled slot count) − (rsp_valid in cycle N ? 1 : 0).
  - A response arriving in cycle N is discarded.
  - First request at the new pc is issued in cycle N+1. Responses to pre-redirect requests never reach the output.
- Back-to-back redirects: each reloads pc; drop_cnt accumulates correctly. It never exceeds DEPTH by construction.
- Full: used + drop_cnt == DEPTH → imem_req_valid=0 until a pop or a drop.
- Stall: inst_ready low holds head stable. The buffer fills and requests stop; no instruction is lost or duplicated.

Test Plan:
- Reset, RESET_PC=0x100, memory ready always, 1-cycle latency, inst_ready=1 → requests at 0x100, 0x104, 0x108… one per cycle; first inst_valid 2 cycles after the first accept; inst_pc matches each word.
- inst_ready=0 for 5 cycles → exactly DEPTH requests outstanding/buffered, then imem_req_valid=0. On release, the sequence resumes with no gap or duplicate.
- imem_req_ready low 3 cycles with valid high → imem_req_addr held at 0x108, pc not advanced.
- Redirect to 0x2003 while 2 requests are in flight → both responses discarded (inst_valid stays low for them); next request addr 0x2000; next delivered inst_pc=0x2000.
- Redirect coincident with rsp_valid and inst_valid&inst_ready → no pop counted, response dropped, drop_cnt correct; subsequent stream starts at redirect target.
- Assert rst_n mid-stream with a full buffer → outputs zero immediately (asynchronously); after release, fetch restarts at RESET_PC with no stale instruction.
